nios2_qsys_mul_seq: RTL and testbench

- Multi-cycle multiply sequencer for the Nios II custom datapath.
- Sits directly upstream of the 32-bit low-product result path. It accepts a 32x32 multiply request, time-multiplexes one registered 16x16 unsigned multiplier across the partial products, and accumulates a 64-bit product.
- Applies signed correction and returns either the low word (mul) or the high word (mulxss/mulxsu/mulxuu) over a valid/ready handshake.

---
 rtl/nios2_qsys_mul_seq.sv | 178 +++++++++++++++++
 tb/tb_nios2_qsys_mul_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_qsys_mul_seq.sv
// rtl/nios2_qsys_mul_seq.sv - multi-cycle 32x32 multiply sequencer built on one registered 16x16 multiplier
module nios2_qsys_mul_seq #(
    parameter bit EARLY_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [1:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;

    // Shift codes for a partial product: 0 -> <<0, 1 -> <<16, 2 -> <<32
    localparam logic [1:0] SH_0  = 2'd0;
    localparam logic [1:0] SH_16 = 2'd1;
    localparam logic [1:0] SH_32 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CORR,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [63:0] r_acc;
    logic [1:0]  r_idx;
    logic [31:0] r_pp;
    logic [1:0]  r_pp_shift;
    logic        r_pp_vld;
    logic [31:0] r_result;
    logic        r_resp_valid;

    logic        w_accept;
    logic        w_issue;
    logic [1:0]  w_last_idx;
    logic [15:0] w_mul_a;
    logic [15:0] w_mul_b;
    logic [31:0] w_mul_p;
    logic [1:0]  w_issue_shift;
    logic [63:0] w_pp_shifted;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_corr_hi;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_issue    = (r_state == S_ISSUE);
    // MUL only needs the low word, and aH*bH lands entirely above bit 31
    assign w_last_idx = (EARLY_LOW && (r_op == OP_MUL)) ? 2'd2 : 2'd3;

    // idx bit 0 selects the high half of A, bit 1 the high half of B:
    // 0=aL*bL, 1=aH*bL, 2=aL*bH, 3=aH*bH
    assign w_mul_a = r_idx[0] ? r_a[31:16] : r_a[15:0];
    assign w_mul_b = r_idx[1] ? r_b[31:16] : r_b[15:0];
    assign w_mul_p = {16'd0, w_mul_a} * {16'd0, w_mul_b};

    // Select the weight of the partial product being issued and the one being accumulated
    always_comb begin
        w_issue_shift = SH_16;
        if (r_idx == 2'd0) begin
            w_issue_shift = SH_0;
        end else if (r_idx == 2'd3) begin
            w_issue_shift = SH_32;
        end
        w_pp_shifted = {r_pp, 32'd0};
        case (r_pp_shift)
            SH_0:    w_pp_shifted = {32'd0, r_pp};
            SH_16:   w_pp_shifted = {16'd0, r_pp, 16'd0};
            default: w_pp_shifted = {r_pp, 32'd0};
        endcase
    end

    // Unsigned high word corrected into the signed high word
    assign w_sa      = r_a[31] && ((r_op == OP_MULXSS) || (r_op == OP_MULXSU));
    assign w_sb      = r_b[31] && (r_op == OP_MULXSS);
    assign w_corr_hi = r_acc[63:32] - (w_sa ? r_b : 32'd0) - (w_sb ? r_a : 32'd0);

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE: if (r_idx == w_last_idx) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_CORR;
            S_CORR:  w_next_state = S_DONE;
            S_DONE:  if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture operands on accept; operand inputs are don't-care afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_op <= 2'd0;
        end else if (w_accept) begin
            r_a  <= req_src1;
            r_b  <= req_src2;
            r_op <= req_op;
        end
    end

    // Issue one partial product per ISSUE cycle into the registered multiplier
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= 2'd0;
            r_pp       <= 32'd0;
            r_pp_shift <= SH_0;
            r_pp_vld   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= 2'd0;
            end else if (w_issue) begin
                r_idx <= r_idx + 2'd1;
            end
            r_pp_vld <= w_issue;
            if (w_issue) begin
                r_pp       <= w_mul_p;
                r_pp_shift <= w_issue_shift;
            end
        end
    end

    // Accumulate each product the cycle after it was issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= 64'd0;
        end else if (w_accept) begin
            r_acc <= 64'd0;
        end else if (r_pp_vld) begin
            r_acc <= r_acc + w_pp_shifted;
        end
    end

    // Form the result in CORR and hold it until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result     <= 32'd0;
            r_resp_valid <= 1'b0;
        end else if (r_state == S_CORR) begin
            r_result     <= (r_op == OP_MUL) ? r_acc[31:0] : w_corr_hi;
            r_resp_valid <= 1'b1;
        end else if ((r_state == S_DONE) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_result;

endmodule

// File: tb/tb_nios2_qsys_mul_seq.sv
// tb/tb_nios2_qsys_mul_seq.sv - self-checking bench for nios2_qsys_mul_seq (EARLY_LOW=1 and EARLY_LOW=0 builds)
module tb_nios2_qsys_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [31:0] req_src1    [2];
    logic [31:0] req_src2    [2];
    logic [1:0]  req_op      [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_result [2];
    logic        busy        [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios2_qsys_mul_seq #(.EARLY_LOW(1'b1)) u_dut_early (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_src1(req_src1[0]), .req_src2(req_src2[0]), .req_op(req_op[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_result(resp_result[0]), .busy(busy[0])
    );

    nios2_qsys_mul_seq #(.EARLY_LOW(1'b0)) u_dut_full (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_src1(req_src1[1]), .req_src2(req_src2[1]), .req_op(req_op[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_result(resp_result[1]), .busy(busy[1])
    );

    // Reference: sign/zero-extend to 64 bits, multiply, pick the word
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (op == 2'b01 || op == 2'b10) ea = {{32{a[31]}}, a};
        if (op == 2'b01) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // One full transaction on instance w with 'stall' cycles of backpressure after resp_valid
    task automatic do_txn(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input int stall, input string name);
        int n;
        int lat;
        logic [31:0] exp;
        logic [31:0] held;
        exp = model(a, b, op);
        lat = (op == 2'b00 && w == 0) ? 5 : 6;
        req_valid[w]  = 1'b1;
        req_src1[w]   = a;
        req_src2[w]   = b;
        req_op[w]     = op;
        resp_ready[w] = (stall == 0);
        checks++;
        if (req_ready[w] !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready[w]);
        end
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        req_src1[w]  = $urandom;
        req_src2[w]  = $urandom;
        req_op[w]    = 2'($urandom_range(0, 3));
        n = 0;
        while (resp_valid[w] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        checks++;
        if (resp_result[w] !== exp) begin
            errors++;
            $display("FAIL %s result a=%h b=%h op=%0d: got %h want %h", name, a, b, op, resp_result[w], exp);
        end
        held = resp_result[w];
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid[w] !== 1'b1 || resp_result[w] !== held || req_ready[w] !== 1'b0 || busy[w] !== 1'b1) begin
                errors++;
                $display("FAIL %s stall%0d: got valid=%b result=%h ready=%b busy=%b want 1 %h 0 1",
                         name, k, resp_valid[w], resp_result[w], req_ready[w], busy[w], held);
            end
        end
        resp_ready[w] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid[w] !== 1'b0 || req_ready[w] !== 1'b1 || busy[w] !== 1'b0) begin
            errors++;
            $display("FAIL %s after fire: got valid=%b ready=%b busy=%b want 0 1 0",
                     name, resp_valid[w], req_ready[w], busy[w]);
        end
    endtask

    task automatic check_idle(input int w, input string name);
        checks++;
        if (req_ready[w] !== 1'b1 || resp_valid[w] !== 1'b0 || resp_result[w] !== 32'd0 || busy[w] !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ready=%b valid=%b result=%h busy=%b want 1 0 00000000 0",
                     name, req_ready[w], resp_valid[w], resp_result[w], busy[w]);
        end
    endtask

    // Reset values while req_valid is held high; accept on the first edge after release
    task automatic test_reset();
        reset = 1'b1;
        req_valid[0] = 1'b1;
        req_src1[0]  = 32'h0001_0003;
        req_src2[0]  = 32'h0002_0005;
        req_op[0]    = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle(0, "reset_early");
            check_idle(1, "reset_full");
        end
        reset = 1'b0;
        do_txn(0, 32'h0001_0003, 32'h0002_0005, 2'b00, 0, "mul_after_reset");
    endtask

    task automatic test_corners();
        do_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0, "mulxuu_ones");
        do_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 0, "mulxss_ones");
        do_txn(0, 32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 0, "mulxsu_neg1x2");
        do_txn(0, 32'h8000_0000, 32'h0000_0002, 2'b01, 0, "mulxss_min");
        do_txn(0, 32'h8000_0000, 32'h8000_0000, 2'b01, 0, "mulxss_minmin");
        do_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, "mul_ones");
    endtask

    task automatic test_back_to_back();
        do_txn(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 4, "backpressure");
        do_txn(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b10, 0, "back_to_back");
    endtask

    task automatic test_reset_mid_op();
        req_valid[0]  = 1'b1;
        req_src1[0]   = 32'hCAFE_F00D;
        req_src2[0]   = 32'h1357_9BDF;
        req_op[0]     = 2'b11;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b valid=%b busy=%b want 1 0 0", req_ready[0], resp_valid[0], busy[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet%0d: got valid=%b busy=%b want 0 0", i, resp_valid[0], busy[0]);
            end
        end
        do_txn(0, 32'd3, 32'd5, 2'b11, 0, "mulxuu_3x5");
        do_txn(0, 32'd3, 32'd5, 2'b00, 0, "mul_3x5");
    endtask

    task automatic test_full_build();
        do_txn(1, 32'h0001_0003, 32'h0002_0005, 2'b00, 0, "full_mul");
        do_txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1, "full_mulxss");
        for (int i = 0; i < 10; i++) begin
            do_txn(1, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2), "full_rand");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_txn(0, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2), "early_rand");
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int w = 0; w < 2; w++) begin
            req_valid[w]  = 1'b0;
            req_src1[w]   = 32'd0;
            req_src2[w]   = 32'd0;
            req_op[w]     = 2'd0;
            resp_ready[w] = 1'b0;
        end
        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_mid_op();
        test_full_build();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
